mu_receipt_issuer: RTL
======================

// Module: mu_receipt_issuer
// PURPOSE
//  Transmit side of the mu-receipt handshake. It watches the instruction stream and the mu-core's
//  receipt_required flag, computes the instruction's mu-cost and the resulting post-mu, and presents
//  exactly one receipt per receipt-requiring instruction. It holds the receipt until the mu-core
//  accepts it, the instruction is withdrawn, or a timeout expires, and tracks chain continuity (last post-mu).
// PARAMETERS
//  MDLACC_BASE     8    base mu-cost of OPC_MDLACC (0x05)
//  PDISCOVER_BASE  16   base mu-cost of OPC_PDISCOVER (0x06)
//  TIMEOUT_CYCLES  15   max cycles in PRESENT before timeout (1..255)
// PORTS
//  clk               in   1   clock
//  rst               in   1   synchronous reset, active-high
//  instruction       in   32  [31:24] opcode, [23:0] operand
//  instr_valid       in   1   instruction present
//  receipt_required  in   1   from mu-core: current instruction needs a receipt
//  current_mu_cost   in   32  pre-mu of the current instruction
//  receipt_accepted  in   1   from mu-core: receipt taken
//  receipt_valid     out  1   receipt presented
//  receipt_value     out  32  post-mu = current_mu_cost + instr cost
//  proposed_cost     out  32  same value as receipt_value, held through PRESENT
//  chain_post_mu     out  32  post-mu of the last accepted receipt
//  receipts_issued   out  16  count of accepted receipts
//  chain_err         out  1   1-cycle pulse: pre-mu != chain_post_mu at capture
//  overflow_err      out  1   1-cycle pulse: post-mu overflowed 32 bits
//  timeout_err       out  1   1-cycle pulse: PRESENT timed out
//  busy              out  1   state != IDLE
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; timeout counter 0. Reset mid-operation aborts immediately with no pulses.
//  - States: IDLE, CALC, PRESENT, WAIT_DROP.
//  - IDLE: on instr_valid && receipt_required, capture the opcode, operand[7:0] and current_mu_cost, then go to CALC.
//    chain_err pulses (the same cycle) if the captured pre-mu != chain_post_mu; the receipt is still issued.
//  - CALC (1 cycle): instruction cost = base + operand[7:0] (base 0 for any other opcode).
//    33-bit sum = pre-mu + cost; if carry, pulse overflow_err and go to WAIT_DROP with no receipt.
//    Otherwise register receipt_value = proposed_cost = sum[31:0] and go to PRESENT.
//  - Latency: trigger at cycle T -> receipt_valid high from T+2.
//  - PRESENT: receipt_valid=1 and value stable; timeout counter increments each cycle.
//    * receipt_accepted: chain_post_mu <= receipt_value; receipts_issued += 1 (wraps 0xFFFF->0); go to WAIT_DROP.
//    * else if !instr_valid: abort to IDLE, no count, no chain update.
//    * else if counter == TIMEOUT_CYCLES-1: pulse timeout_err, go to WAIT_DROP.
//    * accepted && !instr_valid in the same cycle: acceptance wins.
//  - WAIT_DROP: receipt_valid=0; go to IDLE once instr_valid=0. This gives one receipt per instruction.
//    The counter clears on entering IDLE.
//  - receipt_valid is low outside PRESENT; receipt_value and proposed_cost keep their last value.
//  - In CALC, instr_valid=0 aborts to IDLE with no receipt.
//  - Error pulses last exactly 1 cycle and are mutually exclusive per instruction,
//    except chain_err, which can accompany either other error.
// TESTING
//  1. Reset, then MDLACC 0x05000003 with mu=0 -> receipt_valid at T+2, value 11; accept -> chain_post_mu=11, issued=1.
//  2. Chained PDISCOVER 0x06000004 with mu=11 -> value 31, no chain_err. Repeat with mu=12 -> chain_err pulse, value 32.
//  3. PDISCOVER 0x060000FF with mu=0xFFFFFF00 -> overflow_err pulse, receipt_valid never rises, IDLE after instr_valid drops.
//  4. Never accept, TIMEOUT_CYCLES=15 -> receipt_valid high exactly 15 cycles, then timeout_err, no count or chain update.
//  5. Drop instr_valid in PRESENT -> IDLE next cycle, issued unchanged. Accept and drop in the same cycle -> counted.
//  6. Assert rst in PRESENT -> next cycle all outputs 0. Drive issued to 0xFFFF, accept once more -> 0x0000.

Source files
------------

// File: rtl/mu_receipt_issuer_if.sv
// Handshake bundle between the instruction/mu-core side and the receipt issuer.
interface mu_receipt_issuer_if;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        receipt_required;
  logic [31:0] current_mu_cost;
  logic        receipt_accepted;
  logic        receipt_valid;
  logic [31:0] receipt_value;
  logic [31:0] proposed_cost;
  logic [31:0] chain_post_mu;
  logic [15:0] receipts_issued;
  logic        chain_err;
  logic        overflow_err;
  logic        timeout_err;
  logic        busy;

  modport master (
    output instruction, instr_valid, receipt_required, current_mu_cost, receipt_accepted,
    input  receipt_valid, receipt_value, proposed_cost, chain_post_mu, receipts_issued,
           chain_err, overflow_err, timeout_err, busy
  );

  modport slave (
    input  instruction, instr_valid, receipt_required, current_mu_cost, receipt_accepted,
    output receipt_valid, receipt_value, proposed_cost, chain_post_mu, receipts_issued,
           chain_err, overflow_err, timeout_err, busy
  );
endinterface

// File: rtl/mu_receipt_issuer.sv
// Issues one mu-receipt per receipt-requiring instruction and tracks chain continuity.
// Latency: trigger at T -> receipt_valid from T+2; receipt held until accepted, withdrawn or timed out.
module mu_receipt_issuer #(
  parameter int unsigned MDLACC_BASE    = 8,
  parameter int unsigned PDISCOVER_BASE = 16,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  mu_receipt_issuer_if.slave   bus
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_CALC      = 2'd1;
  localparam logic [1:0] S_PRESENT   = 2'd2;
  localparam logic [1:0] S_WAIT_DROP = 2'd3;

  localparam logic [7:0]  OPC_MDLACC    = 8'h05;
  localparam logic [7:0]  OPC_PDISCOVER = 8'h06;
  localparam logic [31:0] MDL_BASE      = 32'(MDLACC_BASE);
  localparam logic [31:0] PDS_BASE      = 32'(PDISCOVER_BASE);
  localparam logic [7:0]  TMO_LAST      = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q,     state_d;
  logic [7:0]  opc_q,       opc_d;
  logic [7:0]  opnd_q,      opnd_d;
  logic [31:0] pre_mu_q,    pre_mu_d;
  logic [31:0] value_q,     value_d;
  logic [31:0] chain_q,     chain_d;
  logic [15:0] issued_q,    issued_d;
  logic [7:0]  tmo_q,       tmo_d;
  logic        chain_err_q, chain_err_d;
  logic        ovf_err_q,   ovf_err_d;
  logic        tmo_err_q,   tmo_err_d;

  logic [31:0] base_cost;
  logic [31:0] instr_cost;
  logic [32:0] post_mu_sum;

  always_comb begin
    base_cost = 32'd0;
    if (opc_q == OPC_MDLACC)         base_cost = MDL_BASE;
    else if (opc_q == OPC_PDISCOVER) base_cost = PDS_BASE;
    instr_cost  = base_cost + {24'd0, opnd_q};
    post_mu_sum = {1'b0, pre_mu_q} + {1'b0, instr_cost};
  end

  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    opnd_d      = opnd_q;
    pre_mu_d    = pre_mu_q;
    value_d     = value_q;
    chain_d     = chain_q;
    issued_d    = issued_q;
    tmo_d       = tmo_q;
    chain_err_d = 1'b0;
    ovf_err_d   = 1'b0;
    tmo_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmo_d = 8'd0;
        if (bus.instr_valid && bus.receipt_required) begin
          opc_d       = bus.instruction[31:24];
          opnd_d      = bus.instruction[7:0];
          pre_mu_d    = bus.current_mu_cost;
          chain_err_d = (bus.current_mu_cost != chain_q);
          state_d     = S_CALC;
        end
      end
      S_CALC: begin
        if (!bus.instr_valid) begin
          state_d = S_IDLE;
        end else if (post_mu_sum[32]) begin
          ovf_err_d = 1'b1;
          state_d   = S_WAIT_DROP;
        end else begin
          value_d = post_mu_sum[31:0];
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        tmo_d = tmo_q + 8'd1;
        // Acceptance takes priority over a simultaneous withdrawal or timeout.
        if (bus.receipt_accepted) begin
          chain_d  = value_q;
          issued_d = issued_q + 16'd1;
          state_d  = S_WAIT_DROP;
        end else if (!bus.instr_valid) begin
          tmo_d   = 8'd0;
          state_d = S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          tmo_err_d = 1'b1;
          state_d   = S_WAIT_DROP;
        end
      end
      default: begin
        if (!bus.instr_valid) begin
          tmo_d   = 8'd0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      opc_q       <= 8'd0;
      opnd_q      <= 8'd0;
      pre_mu_q    <= 32'd0;
      value_q     <= 32'd0;
      chain_q     <= 32'd0;
      issued_q    <= 16'd0;
      tmo_q       <= 8'd0;
      chain_err_q <= 1'b0;
      ovf_err_q   <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      opc_q       <= opc_d;
      opnd_q      <= opnd_d;
      pre_mu_q    <= pre_mu_d;
      value_q     <= value_d;
      chain_q     <= chain_d;
      issued_q    <= issued_d;
      tmo_q       <= tmo_d;
      chain_err_q <= chain_err_d;
      ovf_err_q   <= ovf_err_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  assign bus.receipt_valid   = (state_q == S_PRESENT);
  assign bus.receipt_value   = value_q;
  assign bus.proposed_cost   = value_q;
  assign bus.chain_post_mu   = chain_q;
  assign bus.receipts_issued = issued_q;
  assign bus.chain_err       = chain_err_q;
  assign bus.overflow_err    = ovf_err_q;
  assign bus.timeout_err     = tmo_err_q;
  assign bus.busy            = (state_q != S_IDLE);

endmodule
